// File: rtl/data_mem_responder.sv
// Multi-channel valid/ready memory responder. Each channel services one request at a time with a fixed latency.
// A backdoor port preloads the array and peeks at it.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CHANNELS-1:0]                 read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_CHANNELS-1:0]                 read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]                 write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]                 write_ready,
  input  logic                                    bd_we,
  input  logic [ADDR_WIDTH-1:0]                   bd_addr,
  input  logic [DATA_WIDTH-1:0]                   bd_wdata,
  output logic [DATA_WIDTH-1:0]                   bd_rdata
);

  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_DRAIN} state_e;

  state_e                                  state_q [NUM_CHANNELS];
  state_e                                  state_d [NUM_CHANNELS];
  logic [CNT_W-1:0]                        cnt_q   [NUM_CHANNELS];
  logic [CNT_W-1:0]                        cnt_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]                 is_wr_q, is_wr_d;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_CHANNELS-1:0]                 rd_ready_q, rd_ready_d;
  logic [NUM_CHANNELS-1:0]                 wr_ready_q, wr_ready_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_CHANNELS-1:0]                 mem_we_c;
  logic [NUM_CHANNELS-1:0]                 in_range_c;
  logic                                    bd_in_range_c;
  logic [DATA_WIDTH-1:0]                   mem_q [DEPTH];

  // Range check collapses to constant-true when the address space is fully populated.
  if (64'(DEPTH) >= (64'(1) << ADDR_WIDTH)) begin : g_full_range
    assign in_range_c    = '1;
    assign bd_in_range_c = 1'b1;
  end else begin : g_part_range
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      assign in_range_c[g] = 32'(addr_q[g]) < DEPTH;
    end
    assign bd_in_range_c = 32'(bd_addr) < DEPTH;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_ready_d = '0;
    wr_ready_d = '0;
    rd_data_d  = rd_data_q;
    mem_we_c   = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        S_IDLE: begin
          if (write_valid[ch]) begin
            is_wr_d[ch] = 1'b1;
            addr_d[ch]  = write_addr[ch];
            wdata_d[ch] = write_data[ch];
            cnt_d[ch]   = WR_LOAD;
            state_d[ch] = S_BUSY;
          end else if (read_valid[ch]) begin
            is_wr_d[ch] = 1'b0;
            addr_d[ch]  = read_addr[ch];
            cnt_d[ch]   = RD_LOAD;
            state_d[ch] = S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q[ch] == '0) begin
            state_d[ch] = S_RESP;
            if (is_wr_q[ch]) begin
              wr_ready_d[ch] = 1'b1;
              mem_we_c[ch]   = rst_n & in_range_c[ch];
            end else begin
              rd_ready_d[ch] = 1'b1;
              rd_data_d[ch]  = in_range_c[ch] ? mem_q[IDX_W'(addr_q[ch])] : '0;
            end
          end else begin
            cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
          end
        end
        S_RESP:  state_d[ch] = S_DRAIN;
        // Hold off until the initiator drops the serviced valid so it is never re-accepted.
        S_DRAIN: if (is_wr_q[ch] ? !write_valid[ch] : !read_valid[ch]) state_d[ch] = S_IDLE;
        default: state_d[ch] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= S_IDLE;
        cnt_q[ch]   <= '0;
      end
      is_wr_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage: backdoor first, then channels in ascending order so the highest index wins.
  always_ff @(posedge clk) begin
    if (bd_we && bd_in_range_c) mem_q[IDX_W'(bd_addr)] <= bd_wdata;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (mem_we_c[ch]) mem_q[IDX_W'(addr_q[ch])] <= wdata_q[ch];
    end
  end

  assign read_ready  = rd_ready_q;
  assign write_ready = wr_ready_q;
  assign read_data   = rd_data_q;
  assign bd_rdata    = bd_in_range_c ? mem_q[IDX_W'(bd_addr)] : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: timestamp-based reference model plus directed literal checks.
// A second instance covers READ_LATENCY=1, WRITE_LATENCY=3 and DEPTH=200 (out-of-range addresses).
module tb_data_mem_responder;

  localparam int NCH = 4;
  localparam int RLAT = 2;
  localparam int WLAT = 2;
  localparam int M_DEPTH = 256;
  localparam int ST_FREE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_DRAIN = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] rv, wv, rrdy, wrdy;
  logic [NCH-1:0][7:0] ra, wa, wd, rdata;
  logic bd_we;
  logic [7:0] bd_addr, bd_wdata, bd_rdata;

  logic [NCH-1:0] v_rv, v_wv, v_rrdy, v_wrdy;
  logic [NCH-1:0][7:0] v_ra, v_wa, v_wd, v_rdata;
  logic v_bd_we;
  logic [7:0] v_bd_addr, v_bd_wdata, v_bd_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder u_dut (
    .clk(clk), .rst_n(rst_n),
    .read_valid(rv), .read_addr(ra), .read_ready(rrdy), .read_data(rdata),
    .write_valid(wv), .write_addr(wa), .write_data(wd), .write_ready(wrdy),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  data_mem_responder #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CHANNELS(4), .DEPTH(200),
    .READ_LATENCY(1), .WRITE_LATENCY(3)
  ) u_dut_v (
    .clk(clk), .rst_n(rst_n),
    .read_valid(v_rv), .read_addr(v_ra), .read_ready(v_rrdy), .read_data(v_rdata),
    .write_valid(v_wv), .write_addr(v_wa), .write_data(v_wd), .write_ready(v_wrdy),
    .bd_we(v_bd_we), .bd_addr(v_bd_addr), .bd_wdata(v_bd_wdata), .bd_rdata(v_bd_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each request completes LAT edges after acceptance; channel frees once valid drops.
  int cyc = 0;
  int m_st [NCH];
  int m_due [NCH];
  int m_from [NCH];
  bit m_wr [NCH];
  bit [7:0] m_addr [NCH];
  bit [7:0] m_wd [NCH];
  bit [7:0] mmem [M_DEPTH];
  bit mknown [M_DEPTH];
  bit [NCH-1:0] e_rrdy, e_wrdy;
  bit [7:0] e_rdata [NCH];

  always @(posedge clk) begin : model
    bit [7:0] snap [M_DEPTH];
    bit [NCH-1:0] done;
    cyc++;
    snap = mmem;
    done = '0;
    e_rrdy = '0;
    e_wrdy = '0;
    if (rst_n === 1'b1) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (m_st[ch] == ST_BUSY && m_due[ch] == cyc) begin
          done[ch] = 1'b1;
          if (m_wr[ch]) e_wrdy[ch] = 1'b1;
          else begin
            e_rrdy[ch] = 1'b1;
            e_rdata[ch] = (int'(m_addr[ch]) < M_DEPTH) ? snap[m_addr[ch]] : 8'h00;
          end
        end
      end
    end
    if (bd_we === 1'b1) begin
      mmem[bd_addr] = bd_wdata;
      mknown[bd_addr] = 1'b1;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (done[ch] && m_wr[ch] && int'(m_addr[ch]) < M_DEPTH) begin
        mmem[m_addr[ch]] = m_wd[ch];
        mknown[m_addr[ch]] = 1'b1;
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst_n !== 1'b1) begin
        m_st[ch] = ST_FREE;
        e_rdata[ch] = 8'h00;
      end else if (m_st[ch] == ST_FREE) begin
        if (wv[ch]) begin
          m_st[ch] = ST_BUSY; m_wr[ch] = 1'b1; m_addr[ch] = wa[ch]; m_wd[ch] = wd[ch];
          m_due[ch] = cyc + WLAT;
        end else if (rv[ch]) begin
          m_st[ch] = ST_BUSY; m_wr[ch] = 1'b0; m_addr[ch] = ra[ch];
          m_due[ch] = cyc + RLAT;
        end
      end else if (m_st[ch] == ST_BUSY) begin
        if (done[ch]) begin
          m_st[ch] = ST_DRAIN;
          m_from[ch] = cyc + 2;
        end
      end else if (cyc >= m_from[ch] && !(m_wr[ch] ? wv[ch] : rv[ch])) begin
        m_st[ch] = ST_FREE;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        chk($sformatf("model read_ready[%0d]", ch), 32'(rrdy[ch]), 32'(e_rrdy[ch]));
        chk($sformatf("model write_ready[%0d]", ch), 32'(wrdy[ch]), 32'(e_wrdy[ch]));
        chk($sformatf("model read_data[%0d]", ch), 32'(rdata[ch]), 32'(e_rdata[ch]));
      end
      if (mknown[bd_addr]) chk("model bd_rdata", 32'(bd_rdata), 32'(mmem[bd_addr]));
    end
  end

  function automatic logic [7:0] pat(input int a);
    case (a)
      3:       return 8'h5A;
      5:       return 8'h01;
      8:       return 8'h07;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    rv = '1; wv = '1; ra = '0; wa = '0; wd = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    v_rv = '0; v_wv = '0; v_ra = '0; v_wa = '0; v_wd = '0;
    v_bd_we = 1'b0; v_bd_addr = '0; v_bd_wdata = '0;

    // Reset held with valids high
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_en = 1'b1;
      chk("reset read_ready", 32'(rrdy), 32'h0);
      chk("reset write_ready", 32'(wrdy), 32'h0);
      chk("reset read_data", 32'(rdata), 32'h0);
      chk("reset variant ready", 32'({v_rrdy, v_wrdy}), 32'h0);
    end
    rst_n = 1'b1; rv = '0; wv = '0;
    tick();

    for (int a = 0; a < 256; a++) begin
      bd_we = 1'b1; bd_addr = 8'(a); bd_wdata = pat(a);
      tick();
    end
    bd_we = 1'b0;
    bd_addr = 8'd3;
    #1 chk("preload peek mem[3]", 32'(bd_rdata), 32'h5A);

    // Read latency and held valid
    rv[0] = 1'b1; ra[0] = 8'd3;
    tick(); chk("lat T read_ready", 32'(rrdy), 32'h0);
    tick(); chk("lat T+1 read_ready", 32'(rrdy), 32'h0);
    tick(); chk("lat T+2 read_ready", 32'(rrdy), 32'h1);
    chk("lat T+2 read_data", 32'(rdata[0]), 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("held valid no second ready", 32'(rrdy), 32'h0);
    end
    rv[0] = 1'b0;
    tick(); tick();

    // Parallel writes
    for (int i = 0; i < NCH; i++) begin
      wv[i] = 1'b1; wa[i] = 8'(16 + i); wd[i] = 8'(16 + i);
    end
    tick(); tick(); chk("parallel T+1 write_ready", 32'(wrdy), 32'h0);
    tick(); chk("parallel T+2 write_ready", 32'(wrdy), 32'hF);
    wv = '0;
    tick(); tick();
    for (int i = 0; i < NCH; i++) begin
      bd_addr = 8'(16 + i);
      #1 chk($sformatf("parallel peek mem[%0d]", 16 + i), 32'(bd_rdata), 32'(8'h10 + i));
    end

    // Same-cycle conflicts
    rv[1] = 1'b1; ra[1] = 8'd8;
    wv[2] = 1'b1; wa[2] = 8'd8; wd[2] = 8'h99;
    wv[0] = 1'b1; wa[0] = 8'd9; wd[0] = 8'h11;
    wv[3] = 1'b1; wa[3] = 8'd9; wd[3] = 8'h33;
    tick(); tick(); tick();
    chk("conflict read_ready", 32'(rrdy), 32'h2);
    chk("conflict write_ready", 32'(wrdy), 32'hD);
    chk("conflict read old value", 32'(rdata[1]), 32'h07);
    rv = '0; wv = '0;
    tick(); tick();
    bd_addr = 8'd8;
    #1 chk("conflict peek mem[8]", 32'(bd_rdata), 32'h99);
    bd_addr = 8'd9;
    #1 chk("conflict peek mem[9] highest wins", 32'(bd_rdata), 32'h33);

    // Write priority over read on one channel
    rv[0] = 1'b1; ra[0] = 8'd4;
    wv[0] = 1'b1; wa[0] = 8'd4; wd[0] = 8'hC5;
    tick(); tick(); tick();
    chk("priority write_ready", 32'(wrdy), 32'h1);
    chk("priority read_ready", 32'(rrdy), 32'h0);
    wv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("priority read waits", 32'(rrdy), 32'h0);
    end
    tick();
    chk("priority read_ready late", 32'(rrdy), 32'h1);
    chk("priority read new value", 32'(rdata[0]), 32'hC5);
    rv[0] = 1'b0;
    tick(); tick(); tick();

    // Reset one cycle after accept
    wv[0] = 1'b1; wa[0] = 8'd5; wd[0] = 8'hAB;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid-op reset clears read_data", 32'(rdata), 32'h0);
    rst_n = 1'b1; wv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("mid-op reset no write_ready", 32'(wrdy), 32'h0);
    end
    bd_addr = 8'd5;
    #1 chk("mid-op reset mem[5] kept", 32'(bd_rdata), 32'h01);

    // Variant: READ_LATENCY=1, WRITE_LATENCY=3, DEPTH=200
    v_bd_we = 1'b1; v_bd_addr = 8'd10; v_bd_wdata = 8'h3C;
    tick();
    v_bd_we = 1'b0;
    chk("variant peek mem[10]", 32'(v_bd_rdata), 32'h3C);
    v_rv[1] = 1'b1; v_ra[1] = 8'd10;
    tick(); chk("variant read T", 32'(v_rrdy), 32'h0);
    tick(); chk("variant read T+1", 32'(v_rrdy), 32'h2);
    chk("variant read data", 32'(v_rdata[1]), 32'h3C);
    v_rv[1] = 1'b0;
    tick(); tick(); tick();
    v_rv[1] = 1'b1; v_ra[1] = 8'd250;
    tick(); tick();
    chk("variant oob read ready", 32'(v_rrdy), 32'h2);
    chk("variant oob read data", 32'(v_rdata[1]), 32'h0);
    v_rv[1] = 1'b0;
    tick(); tick(); tick();
    v_wv[2] = 1'b1; v_wa[2] = 8'd220; v_wd[2] = 8'hEE;
    tick(); tick(); chk("variant write T+1", 32'(v_wrdy), 32'h0);
    tick(); chk("variant write T+2", 32'(v_wrdy), 32'h0);
    tick(); chk("variant oob write T+3", 32'(v_wrdy), 32'h4);
    v_wv[2] = 1'b0;
    v_bd_addr = 8'd220;
    #1 chk("variant oob peek", 32'(v_bd_rdata), 32'h0);
    tick(); tick(); tick();
    v_wv[3] = 1'b1; v_wa[3] = 8'd10; v_wd[3] = 8'h77;
    tick(); tick(); tick(); tick();
    chk("variant write ready ch3", 32'(v_wrdy), 32'h8);
    v_wv[3] = 1'b0;
    v_bd_addr = 8'd10;
    #1 chk("variant peek mem[10] after write", 32'(v_bd_rdata), 32'h77);
    tick(); tick(); tick();
    v_rv[0] = 1'b1; v_ra[0] = 8'd10;
    tick(); tick();
    chk("variant read back ready", 32'(v_rrdy), 32'h1);
    chk("variant read back data", 32'(v_rdata[0]), 32'h77);
    v_rv[0] = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
